// File: rtl/midi_pkg.sv
// Definitions shared by the MIDI packet assembler and the MIDI control unit:
// status nibbles, byte classes and the per-command data-byte count.
package midi_pkg;

  localparam logic [3:0] CMD_NOTE_OFF         = 4'h8;
  localparam logic [3:0] CMD_NOTE_ON          = 4'h9;
  localparam logic [3:0] CMD_POLY_PRESSURE    = 4'hA;
  localparam logic [3:0] CMD_CONTROL_CHANGE   = 4'hB;
  localparam logic [3:0] CMD_PROGRAM_CHANGE   = 4'hC;
  localparam logic [3:0] CMD_CHANNEL_PRESSURE = 4'hD;
  localparam logic [3:0] CMD_PITCH_BEND       = 4'hE;
  localparam logic [3:0] CMD_SYSTEM_MESSAGE   = 4'hF;

  typedef enum logic [1:0] {
    BC_DATA,
    BC_CHANNEL,
    BC_COMMON,
    BC_REALTIME
  } byte_class_t;

  typedef enum logic [1:0] {
    NO_STATUS,
    WAIT_D0,
    WAIT_D1,
    DISCARD
  } asm_state_t;

  function automatic byte_class_t byte_class(input logic [7:0] b);
    if (!b[7])                    return BC_DATA;
    else if (b[7:4] != 4'hF)      return BC_CHANNEL;
    else if (!b[3])               return BC_COMMON;
    else                          return BC_REALTIME;
  endfunction

  function automatic logic [1:0] data_count(input logic [3:0] nibble);
    case (nibble)
      CMD_PROGRAM_CHANGE, CMD_CHANNEL_PRESSURE: return 2'd1;
      CMD_SYSTEM_MESSAGE:                       return 2'd0;
      default:                                  return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/midi_packet_assembler.sv
// Builds 3-byte MIDI channel packets from the UART byte stream with running
// status, and spaces the ready strobes at least PKT_GAP cycles apart.
module midi_packet_assembler
  import midi_pkg::*;
#(
  parameter int BYTE_W  = 8,
  parameter int PKT_GAP = 8,
  parameter int GAP_W   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_valid,
  output logic [BYTE_W-1:0] MIDI_CMD,
  output logic [BYTE_W-1:0] MIDI_DAT_0,
  output logic [BYTE_W-1:0] MIDI_DAT_1,
  output logic              MIDI_PACKET_RDY,
  output logic              pkt_dropped
);

  asm_state_t        state;
  logic [BYTE_W-1:0] run_status;
  logic [BYTE_W-1:0] d0_reg;
  logic [GAP_W-1:0]  hold_cnt;
  logic              pend_valid;
  logic [BYTE_W-1:0] pend_cmd, pend_d0, pend_d1;

  byte_class_t       cls;
  logic              complete;
  logic [BYTE_W-1:0] new_d0, new_d1;
  logic              emit_pend;

  assign cls       = byte_class(rx_byte);
  assign emit_pend = (hold_cnt == '0) && pend_valid;

  always_comb begin
    complete = 1'b0;
    new_d0   = d0_reg;
    new_d1   = '0;
    if (rx_valid && cls == BC_DATA) begin
      if (state == WAIT_D0 && data_count(run_status[7:4]) == 2'd1) begin
        complete = 1'b1;
        new_d0   = rx_byte;
      end else if (state == WAIT_D1) begin
        complete = 1'b1;
        new_d1   = rx_byte;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= NO_STATUS;
      run_status <= '0;
      d0_reg     <= '0;
    end else if (rx_valid) begin
      case (cls)
        BC_CHANNEL: begin
          state      <= WAIT_D0;
          run_status <= rx_byte;
          d0_reg     <= '0;
        end
        BC_COMMON: begin
          state      <= DISCARD;
          run_status <= '0;
          d0_reg     <= '0;
        end
        BC_DATA: begin
          if (state == WAIT_D0) begin
            d0_reg <= rx_byte;
            if (data_count(run_status[7:4]) == 2'd2) state <= WAIT_D1;
          end else if (state == WAIT_D1) begin
            state <= WAIT_D0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output stage: an older pending packet always wins the emit slot; a newly
  // completed packet then takes the pending slot (dropping only a packet that
  // is still waiting, never the one just emitted).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt        <= '0;
      pend_valid      <= 1'b0;
      pend_cmd        <= '0;
      pend_d0         <= '0;
      pend_d1         <= '0;
      MIDI_CMD        <= '0;
      MIDI_DAT_0      <= '0;
      MIDI_DAT_1      <= '0;
      MIDI_PACKET_RDY <= 1'b0;
      pkt_dropped     <= 1'b0;
    end else begin
      MIDI_PACKET_RDY <= 1'b0;
      pkt_dropped     <= 1'b0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      if (emit_pend) begin
        MIDI_CMD        <= pend_cmd;
        MIDI_DAT_0      <= pend_d0;
        MIDI_DAT_1      <= pend_d1;
        MIDI_PACKET_RDY <= 1'b1;
        hold_cnt        <= GAP_W'(PKT_GAP - 1);
        pend_valid      <= complete;
        if (complete) begin
          pend_cmd <= run_status;
          pend_d0  <= new_d0;
          pend_d1  <= new_d1;
        end
      end else if (complete) begin
        if (hold_cnt == '0 && !pend_valid) begin
          MIDI_CMD        <= run_status;
          MIDI_DAT_0      <= new_d0;
          MIDI_DAT_1      <= new_d1;
          MIDI_PACKET_RDY <= 1'b1;
          hold_cnt        <= GAP_W'(PKT_GAP - 1);
        end else begin
          pend_valid  <= 1'b1;
          pend_cmd    <= run_status;
          pend_d0     <= new_d0;
          pend_d1     <= new_d1;
          pkt_dropped <= pend_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_packet_assembler.sv
// Self-checking bench for midi_packet_assembler: table vectors, throttle and
// reset sequences, and random byte streams against a behavioural model.
module tb_midi_packet_assembler;

  localparam int PKT_GAP = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] MIDI_CMD, MIDI_DAT_0, MIDI_DAT_1;
  logic       MIDI_PACKET_RDY, pkt_dropped;

  midi_packet_assembler #(.BYTE_W(8), .PKT_GAP(PKT_GAP), .GAP_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .MIDI_CMD(MIDI_CMD), .MIDI_DAT_0(MIDI_DAT_0), .MIDI_DAT_1(MIDI_DAT_1),
    .MIDI_PACKET_RDY(MIDI_PACKET_RDY), .pkt_dropped(pkt_dropped)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural reference: parser keeps running status plus a list of
  // collected data bytes; throttle works on absolute cycle numbers.
  logic [7:0]  m_rs;
  logic [7:0]  m_buf[$];
  logic        m_pend;
  logic [23:0] m_pend_pkt;
  int          m_last_emit;
  logic        e_rdy, e_drop;
  logic [23:0] e_pkt;

  int          rdy_cyc_q[$];
  logic [23:0] rdy_pkt_q[$];
  int          drop_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rs = 8'h00;
    m_buf.delete();
    m_pend = 1'b0;
    m_pend_pkt = '0;
    m_last_emit = -1000;
    e_rdy = 1'b0;
    e_drop = 1'b0;
    e_pkt = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    logic        got;
    logic [23:0] pkt;
    int          need;
    logic        allowed;
    got = 1'b0;
    pkt = '0;
    if (v) begin
      if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
        m_rs = 8'h00;
        m_buf.delete();
      end else if (b >= 8'h80) begin
        m_rs = b;
        m_buf.delete();
      end else if (m_rs != 8'h00) begin
        need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
        m_buf.push_back(b);
        if (m_buf.size() == need) begin
          got = 1'b1;
          pkt = {m_rs, m_buf[0], (need == 2) ? m_buf[1] : 8'h00};
          m_buf.delete();
        end
      end
    end
    e_rdy = 1'b0;
    e_drop = 1'b0;
    allowed = (cyc - m_last_emit) >= PKT_GAP;
    if (allowed && m_pend) begin
      e_pkt = m_pend_pkt; e_rdy = 1'b1; m_last_emit = cyc;
      m_pend = got;
      if (got) m_pend_pkt = pkt;
    end else if (got) begin
      if (allowed) begin
        e_pkt = pkt; e_rdy = 1'b1; m_last_emit = cyc;
      end else begin
        e_drop = m_pend;
        m_pend = 1'b1;
        m_pend_pkt = pkt;
      end
    end
  endtask

  task automatic check_outputs();
    chk("rdy", 32'(MIDI_PACKET_RDY), 32'(e_rdy));
    chk("dropped", 32'(pkt_dropped), 32'(e_drop));
    chk("cmd", 32'(MIDI_CMD), 32'(e_pkt[23:16]));
    chk("dat0", 32'(MIDI_DAT_0), 32'(e_pkt[15:8]));
    chk("dat1", 32'(MIDI_DAT_1), 32'(e_pkt[7:0]));
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    rx_valid = v;
    rx_byte  = b;
    @(posedge sys_clk);
    cyc++;
    model_step(v, b);
    #1;
    check_outputs();
    if (MIDI_PACKET_RDY) begin
      rdy_cyc_q.push_back(cyc);
      rdy_pkt_q.push_back({MIDI_CMD, MIDI_DAT_0, MIDI_DAT_1});
    end
    if (pkt_dropped) drop_cnt++;
    $display("cyc %0d in v=%0d b=%02h -> rdy=%0d drop=%0d pkt=%02h %02h %02h", cyc, v, b,
             MIDI_PACKET_RDY, pkt_dropped, MIDI_CMD, MIDI_DAT_0, MIDI_DAT_1);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic clear_log();
    rdy_cyc_q.delete();
    rdy_pkt_q.delete();
    drop_cnt = 0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       rdy;
    logic [7:0] cmd, d0, d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] b, input logic rdy, input logic [7:0] c,
                              input logic [7:0] d0, input logic [7:0] d1);
    vec_t v;
    v.b = b; v.rdy = rdy; v.cmd = c; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  initial begin
    int c1;
    int r;
    logic [7:0] rb;

    model_reset();
    clear_log();
    repeat (3) @(posedge sys_clk);
    #1;
    check_outputs();
    sys_rst_n = 1'b1;

    vecs.push_back(mk(8'h91, 0, 0, 0, 0));
    vecs.push_back(mk(8'h3C, 0, 0, 0, 0));
    vecs.push_back(mk(8'h64, 1, 8'h91, 8'h3C, 8'h64));
    vecs.push_back(mk(8'h90, 0, 0, 0, 0));
    vecs.push_back(mk(8'h3C, 0, 0, 0, 0));
    vecs.push_back(mk(8'h64, 1, 8'h90, 8'h3C, 8'h64));
    vecs.push_back(mk(8'h40, 0, 0, 0, 0));
    vecs.push_back(mk(8'h00, 1, 8'h90, 8'h40, 8'h00));
    vecs.push_back(mk(8'h90, 0, 0, 0, 0));
    vecs.push_back(mk(8'hF8, 0, 0, 0, 0));
    vecs.push_back(mk(8'h3C, 0, 0, 0, 0));
    vecs.push_back(mk(8'hFE, 0, 0, 0, 0));
    vecs.push_back(mk(8'h64, 1, 8'h90, 8'h3C, 8'h64));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h12, 0, 0, 0, 0));
    vecs.push_back(mk(8'hF7, 0, 0, 0, 0));
    vecs.push_back(mk(8'h3C, 0, 0, 0, 0));
    vecs.push_back(mk(8'hC2, 0, 0, 0, 0));
    vecs.push_back(mk(8'h05, 1, 8'hC2, 8'h05, 8'h00));
    vecs.push_back(mk(8'h07, 1, 8'hC2, 8'h07, 8'h00));

    // Bytes spaced by idle cycles so the holdoff is always clear.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].b);
      chk("tbl_rdy", 32'(MIDI_PACKET_RDY), 32'(vecs[i].rdy));
      if (vecs[i].rdy)
        chk("tbl_pkt", {8'h00, MIDI_CMD, MIDI_DAT_0, MIDI_DAT_1},
            {8'h00, vecs[i].cmd, vecs[i].d0, vecs[i].d1});
      idle(9);
    end

    // Second packet completes 3 cycles after the first: held to 8 cycles.
    clear_log();
    step(1'b1, 8'h90); step(1'b1, 8'h3C); step(1'b1, 8'h64);
    c1 = cyc;
    step(1'b0, 8'h00); step(1'b1, 8'h40); step(1'b1, 8'h50);
    idle(12);
    chk("thr_count", 32'(rdy_cyc_q.size()), 32'd2);
    if (rdy_cyc_q.size() == 2) begin
      chk("thr_first", 32'(rdy_cyc_q[0]), 32'(c1));
      chk("thr_gap", 32'(rdy_cyc_q[1] - rdy_cyc_q[0]), 32'(PKT_GAP));
      chk("thr_pkt2", 32'(rdy_pkt_q[1]), 32'h00904050);
    end
    chk("thr_nodrop", 32'(drop_cnt), 32'd0);

    // Third packet overwrites the pending second one.
    clear_log();
    step(1'b1, 8'h90); step(1'b1, 8'h3C); step(1'b1, 8'h64);
    c1 = cyc;
    step(1'b0, 8'h00); step(1'b1, 8'h41); step(1'b1, 8'h51);
    step(1'b0, 8'h00); step(1'b1, 8'h42); step(1'b1, 8'h52);
    idle(12);
    chk("drop_count", 32'(drop_cnt), 32'd1);
    chk("drop_rdys", 32'(rdy_cyc_q.size()), 32'd2);
    if (rdy_cyc_q.size() == 2) begin
      chk("drop_gap", 32'(rdy_cyc_q[1] - c1), 32'(PKT_GAP));
      chk("drop_pkt", 32'(rdy_pkt_q[1]), 32'h00904252);
    end

    // Asynchronous reset mid-packet.
    clear_log();
    step(1'b1, 8'h90); step(1'b1, 8'h3C);
    #3 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    step(1'b1, 8'h64);
    idle(3);
    chk("rst_rdys", 32'(rdy_cyc_q.size()), 32'd0);
    chk("rst_outs", {8'h00, MIDI_CMD, MIDI_DAT_0, MIDI_DAT_1}, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      rb = 8'($urandom_range(8'h00, 8'h7F));
      else if (r < 70) rb = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 78) rb = 8'($urandom_range(8'hF0, 8'hF7));
      else             rb = 8'($urandom_range(8'hF8, 8'hFF));
      step($urandom_range(0, 9) < 7, rb);
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
